// File: rtl/square_accumulate_pkt.sv
// Packet sum-of-squares accumulator: squares each sample in stage 1 and accumulates
// bias plus the squares in stage 2. Emits one result per packet behind a valid/ready handshake.
module square_accumulate_pkt #(
  parameter int unsigned A_WIDTH  = 8,
  parameter int unsigned Z_WIDTH  = 24,
  parameter int unsigned SIGNED   = 1,
  parameter int unsigned SATURATE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [A_WIDTH-1:0] s_data,
  input  logic               s_last,
  input  logic [Z_WIDTH-1:0] bias,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [Z_WIDTH-1:0] m_data,
  output logic               m_overflow
);

  localparam int unsigned SQ_W  = 2 * A_WIDTH;
  localparam int unsigned SUM_W = Z_WIDTH + 1;

  typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;

  state_t             state_q, state_d;
  logic               s_ready_q, s_ready_d;
  logic               sq_valid_q, sq_last_q;
  logic [SQ_W-1:0]    sq_q;
  logic [Z_WIDTH-1:0] acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               first_q, first_d;
  logic               m_valid_q, m_valid_d;
  logic [Z_WIDTH-1:0] m_data_q, m_data_d;
  logic               m_ovf_q, m_ovf_d;

  logic               beat_c;
  logic [SQ_W-1:0]    a_ext_c;
  logic [SQ_W-1:0]    sq_c;
  logic [Z_WIDTH-1:0] base_c;
  logic [SUM_W-1:0]   sum_c;

  assign beat_c = s_valid && s_ready_q;

  // Square of a sign- or zero-extended sample; the square is never negative, so the
  // low 2*A_WIDTH product bits hold the full magnitude.
  always_comb begin
    a_ext_c = (SIGNED != 0) ? SQ_W'($signed(s_data)) : SQ_W'(s_data);
    sq_c    = a_ext_c * a_ext_c;
  end

  assign base_c = first_q ? bias : acc_q;
  assign sum_c  = SUM_W'(base_c) + SUM_W'(sq_q);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    first_d   = first_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ovf_d   = m_ovf_q;

    if (sq_valid_q) begin
      first_d = sq_last_q;
      if (sum_c[Z_WIDTH]) begin
        ovf_d = 1'b1;
        acc_d = (SATURATE != 0) ? {Z_WIDTH{1'b1}} : sum_c[Z_WIDTH-1:0];
      end else begin
        acc_d = sum_c[Z_WIDTH-1:0];
      end
    end

    case (state_q)
      ACCUM:  if (beat_c && s_last) state_d = DRAIN;
      DRAIN:  state_d = OUTPUT;
      OUTPUT: begin
        // First OUTPUT cycle captures the settled accumulator into the result registers.
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = acc_q;
          m_ovf_d   = ovf_q;
        end else if (m_ready) begin
          state_d   = ACCUM;
          m_valid_d = 1'b0;
          m_data_d  = '0;
          m_ovf_d   = 1'b0;
          acc_d     = '0;
          ovf_d     = 1'b0;
          first_d   = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase

    s_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      s_ready_q  <= 1'b0;
      sq_valid_q <= 1'b0;
      sq_last_q  <= 1'b0;
      sq_q       <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      first_q    <= 1'b1;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_ovf_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= s_ready_d;
      sq_valid_q <= beat_c;
      if (beat_c) begin
        sq_q      <= sq_c;
        sq_last_q <= s_last;
      end
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      first_q    <= first_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_ovf_q    <= m_ovf_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_overflow = m_ovf_q;

endmodule

// File: doc/square_accumulate_pkt.md
SQUARE_ACCUMULATE_PKT -- requirements
Module: square_accumulate_pkt

Interface
REQ-001: Parameter A_WIDTH, default 8; sample width in bits.
REQ-002: Parameter Z_WIDTH, default 24; accumulator and result width; Z_WIDTH >= 2*A_WIDTH is a legal-configuration requirement.
REQ-003: Parameter SIGNED, default 1; 1 = samples are two's complement, 0 = samples are unsigned.
REQ-004: Parameter SATURATE, default 1; 1 = clamp accumulator at 2^Z_WIDTH-1, 0 = wrap modulo 2^Z_WIDTH.
REQ-005: clk  input  1  single clock; all state updates on its rising edge.
REQ-006: rst_n  input  1  asynchronous, active-low reset.
REQ-007: s_valid  input  1  input sample valid.
REQ-008: s_ready  output  1  block can accept a sample.
REQ-009: s_data  input  A_WIDTH  sample to be squared.
REQ-010: s_last  input  1  marks the final sample of a packet.
REQ-011: bias  input  Z_WIDTH  initial accumulator value for a packet.
REQ-012: m_valid  output  1  result valid.
REQ-013: m_ready  input  1  downstream accepts result.
REQ-014: m_data  output  Z_WIDTH  bias plus sum of squares of the packet.
REQ-015: m_overflow  output  1  result exceeded 2^Z_WIDTH-1 during the packet.

Function
REQ-016: A beat transfers on a rising edge where s_valid && s_ready; there is no other way a beat is consumed.
REQ-017: Stage 1 registers the square: sq = s_data*s_data with a 2*A_WIDTH-bit result, signed or unsigned per SIGNED; sq_last is registered alongside it.
REQ-018: Stage 2 processes the first square of a packet as acc = bias + sq.
  - bias is sampled on the edge at which that square enters stage 2.
  - Every later square of the packet adds: acc = acc + sq.
REQ-019: Arithmetic uses a Z_WIDTH+1-bit sum.
  - If bit Z_WIDTH is set: the sticky packet overflow flag is set.
  - SATURATE=1: acc = 2^Z_WIDTH-1 and remains there for the rest of the packet.
  - SATURATE=0: acc = sum mod 2^Z_WIDTH.
REQ-020: State machine has three states.
  - ACCUM: s_ready=1; a beat with s_last=0 stays in ACCUM; a beat with s_last=1 goes to DRAIN.
  - DRAIN: s_ready=0, for exactly one cycle while the last square passes stage 2; then goes to OUTPUT.
  - OUTPUT: m_valid=1, s_ready=0; returns to ACCUM on the edge where m_ready=1.
REQ-021: Latency: if the last beat transfers on edge k, m_valid is 1 after edge k+2 with m_data and m_overflow final.
REQ-022: While m_valid=1 and m_ready=0, m_data and m_overflow are held stable and no input is accepted.
REQ-023: After the output handshake edge: m_valid=0 and s_ready=1 in the following cycle; acc and the overflow flag are cleared for the next packet.
REQ-024: A single-beat packet (first beat has s_last=1) is legal; its result is bias + s_data^2.
REQ-025: Idle cycles (s_valid=0) inside a packet do not alter acc.
REQ-026: m_overflow is 0 whenever m_valid=0.

Reset
REQ-027: rst_n=0 asynchronously forces:
  - state=ACCUM, acc=0, overflow flag=0, stage-1 valid=0;
  - m_valid=0, m_data=0, m_overflow=0.
REQ-028: s_ready is 0 while rst_n=0 and 1 from the first rising edge after rst_n is released.
REQ-029: Assertion of rst_n=0 mid-packet or mid-OUTPUT discards all partial results; no m_valid pulse follows the release.

Verification
REQ-030: Defaults, bias=5, samples 3,-4,2(last), m_ready=1 -> m_data=34, m_overflow=0, m_valid rises 2 edges after the last beat.
REQ-031: SIGNED=0, bias=0, single beat 8'hFF last -> m_data=65025; same beat with SIGNED=1 -> m_data=1.
REQ-032: Z_WIDTH=16, SATURATE=1, bias=0, samples -128 x4 (last on 4th) -> m_data=65535, m_overflow=1; SATURATE=0 -> m_data=0, m_overflow=1.
REQ-033: Backpressure: hold m_ready=0 for 10 cycles with s_valid=1 -> s_ready=0 throughout and m_data stable; m_ready=1 -> handshake, s_ready=1 next cycle, next packet bias=0, samples 1,1(last) -> m_data=2.
REQ-034: rst_n pulsed low during the 2nd beat of a 3-beat packet -> outputs 0 immediately; new packet bias=0, sample 7(last) -> m_data=49, with no stale result emitted.
REQ-035: Gapped input: samples 2, idle x3, 2(last), bias=1 -> m_data=9.
